// File: rtl/xor_pkg.sv
// Shared widths, FSM encoding and byte-placement helper for the XOR block encoder.
package xor_pkg;

  localparam int BLOCK_W         = 64;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 8;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Byte k lands at bits [8k : 8k+7]; byte 0 is the leftmost byte of the block.
  function automatic logic [0:BLOCK_W-1] put_byte(input logic [0:BLOCK_W-1] blk,
                                                  input logic [2:0]         idx,
                                                  input logic [0:BYTE_W-1]  b);
    logic [0:BLOCK_W-1] r;
    r = blk;
    r[{idx, 3'b000} +: BYTE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/xor_block_mask.sv
// Combinational 64-bit key mask: bit i of the key masks bit i of the data.
module xor_block_mask
  import xor_pkg::*;
(
  input  logic [0:BLOCK_W-1] data,
  input  logic [0:BLOCK_W-1] key,
  output logic [0:BLOCK_W-1] masked
);

  assign masked = data ^ key;

endmodule

// File: rtl/xor_block_encoder.sv
// Packs plaintext bytes into 64-bit blocks, masks them with a latched key and
// hands each block out through a valid/ready port.
module xor_block_encoder
  import xor_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_load,
  input  logic [0:BLOCK_W-1] key_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:BYTE_W-1]  in_byte,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:BLOCK_W-1] out_block,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_last
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [0:BLOCK_W-1] key_q;
  logic [0:BLOCK_W-1] blk_q;
  logic [0:BLOCK_W-1] blk_next;
  logic [0:BLOCK_W-1] masked_blk;
  logic [0:BLOCK_W-1] out_block_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_last_q;
  logic               rdy_q;
  logic               accept;
  logic               complete;
  logic               load_key;
  logic               send_done;

  // Unwritten byte positions of blk_q are always zero, so masking blk_next
  // directly yields the zero-padded ciphertext.
  xor_block_mask u_mask (
    .data   (blk_next),
    .key    (key_q),
    .masked (masked_blk)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_key  = 1'b0;
    send_done = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    blk_next  = blk_q;
    case (state_q)
      ST_IDLE: begin
        // A key load takes the cycle, so the new key applies from the next block on.
        load_key = rdy_q & key_load;
        in_ready = rdy_q & ~key_load;
      end
      ST_FILL: in_ready = 1'b1;
      ST_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          send_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
      complete = in_last | (cnt_q == CNT_W'(BYTES_PER_BLOCK - 1));
      blk_next = put_byte(blk_q, cnt_q[2:0], in_byte);
      state_d  = complete ? ST_SEND : ST_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      blk_q       <= '0;
      out_block_q <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      if (load_key) key_q <= key_in;
      if (accept) begin
        cnt_q <= cnt_q + CNT_W'(1);
        blk_q <= blk_next;
        if (complete) begin
          out_block_q <= masked_blk;
          out_count_q <= cnt_q + CNT_W'(1);
          out_last_q  <= in_last;
        end
      end
      if (send_done) begin
        cnt_q <= '0;
        blk_q <= '0;
      end
    end
  end

  assign out_block = out_block_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_xor_block_encoder.sv
// Directed bench for xor_block_encoder with hand-computed ciphertext vectors.
module tb_xor_block_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_load;
  logic [0:63] key_in;
  logic        in_valid;
  logic        in_ready;
  logic [0:7]  in_byte;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] out_block;
  logic [3:0]  out_count;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] KEY_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_F = 64'hFFFFFFFFFFFFFFFF;

  xor_block_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_count (out_count),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_key(input logic [63:0] k);
    @(negedge clk);
    key_load = 1'b1;
    key_in   = k;
    #1 chk("key_load_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1 key_load = 1'b0;
  endtask

  // Sends one byte; gap idle cycles precede it. exp_done: expect out_valid next.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap,
                           input logic exp_done);
    int n;
    for (int i = 0; i < gap; i++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("out_valid_latency", 64'(out_valid), 64'(exp_done));
  endtask

  task automatic recv_block(input string tag, input logic [63:0] exp_blk,
                            input logic [3:0] exp_cnt, input logic exp_last, input int gap);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_timeout"}, 64'(0), 64'(1));
    for (int i = 0; i < gap; i++) @(negedge clk);
    chk({tag, "_block"}, out_block, exp_blk);
    chk({tag, "_count"}, 64'(out_count), 64'(exp_cnt));
    chk({tag, "_last"},  64'(out_last), 64'(exp_last));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_idle_after"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  logic [63:0] acc;
  logic [7:0]  b;
  int          gap;

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0;
    in_byte = '0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_block", out_block, 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    chk("rst_out_last",  64'(out_last), 64'(0));
    chk("rst_in_ready",  64'(in_ready), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Full block, last on byte 7.
    load_key(KEY_A);
    for (int k = 0; k < 8; k++)
      send_byte(8'(k), k == 7, 0, k == 7);
    recv_block("full8", 64'h012247648DAECBE8, 4'd8, 1'b1, 0);

    // Short block AA BB, zero padding masked by key.
    send_byte(8'hAA, 1'b0, 0, 1'b0);
    send_byte(8'hBB, 1'b1, 0, 1'b1);
    recv_block("short2", 64'hAB98456789ABCDEF, 4'd2, 1'b1, 0);

    // Back-pressure: out_ready low for 5 cycles.
    send_byte(8'h11, 1'b1, 0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_block", out_block, 64'h1023456789ABCDEF);
      chk("bp_valid", 64'(out_valid), 64'(1));
    end
    recv_block("bp", 64'h1023456789ABCDEF, 4'd1, 1'b1, 0);

    // key_load during FILL is ignored.
    send_byte(8'h00, 1'b0, 0, 1'b0);
    @(negedge clk);
    key_load = 1'b1;
    key_in   = KEY_F;
    #1 chk("fill_keyload_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 key_load = 1'b0;
    for (int k = 1; k < 8; k++)
      send_byte(8'(k), 1'b0, 0, k == 7);
    recv_block("keyign", 64'h012247648DAECBE8, 4'd8, 1'b0, 0);

    // Reset mid-block discards data and clears the key.
    send_byte(8'h55, 1'b0, 0, 1'b0);
    send_byte(8'h66, 1'b0, 0, 1'b0);
    send_byte(8'h77, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_no_valid", 64'(out_valid), 64'(0));
    end
    for (int k = 0; k < 8; k++)
      send_byte(8'h00, 1'b0, 0, k == 7);
    recv_block("zerokey", 64'h0, 4'd8, 1'b0, 0);

    // 16 bytes, random gaps, reference model.
    load_key(KEY_A);
    for (int blk = 0; blk < 2; blk++) begin
      acc = '0;
      for (int k = 0; k < 8; k++) begin
        b   = 8'($urandom_range(0, 255));
        gap = $urandom_range(0, 3);
        acc = acc | (64'(b) << (56 - 8 * k));
        send_byte(b, 1'b0, gap, k == 7);
      end
      recv_block("rand", acc ^ KEY_A, 4'd8, 1'b0, $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
